// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of the single SRAM controller.
// The winning request is latched and drives the controller until its ready pulse.
module sram_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WDATA_W = 32,
  parameter int unsigned RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_r_en_in,
  input  logic               req0_w_en_in,
  input  logic [ADDR_W-1:0]  req0_address_in,
  input  logic [WDATA_W-1:0] req0_write_data_in,
  output logic [RDATA_W-1:0] req0_read_data_out,
  output logic               req0_ready_out,
  input  logic               req1_r_en_in,
  input  logic               req1_w_en_in,
  input  logic [ADDR_W-1:0]  req1_address_in,
  input  logic [WDATA_W-1:0] req1_write_data_in,
  output logic [RDATA_W-1:0] req1_read_data_out,
  output logic               req1_ready_out,
  output logic               mem_r_en_out,
  output logic               mem_w_en_out,
  output logic [ADDR_W-1:0]  mem_address_out,
  output logic [WDATA_W-1:0] mem_write_data_out,
  input  logic [RDATA_W-1:0] mem_read_data_in,
  input  logic               mem_ready_in,
  output logic [1:0]         grant_out,
  output logic               busy_out
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_q, last_d;  // index of the port served most recently
  logic               op_w_q, op_w_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WDATA_W-1:0] wdata_q, wdata_d;

  logic req0, req1, pick1;

  assign req0 = req0_r_en_in | req0_w_en_in;
  assign req1 = req1_r_en_in | req1_w_en_in;
  // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_w_d  = op_w_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StBusy;
          grant_d = pick1 ? 2'b10 : 2'b01;
          op_w_d  = pick1 ? req1_w_en_in : req0_w_en_in;
          addr_d  = pick1 ? req1_address_in : req0_address_in;
          wdata_d = pick1 ? req1_write_data_in : req0_write_data_in;
        end
      end
      StBusy: begin
        if (mem_ready_in) begin
          state_d = StIdle;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      op_w_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_w_q  <= op_w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy_out           = (state_q == StBusy);
  assign grant_out          = grant_q;
  assign mem_r_en_out       = busy_out & ~op_w_q;
  assign mem_w_en_out       = busy_out & op_w_q;
  assign mem_address_out    = addr_q;
  assign mem_write_data_out = wdata_q;

  assign req0_ready_out     = busy_out & mem_ready_in & grant_q[0];
  assign req1_ready_out     = busy_out & mem_ready_in & grant_q[1];
  assign req0_read_data_out = mem_read_data_in;
  assign req1_read_data_out = mem_read_data_in;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level round-robin model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_r_en_in, req0_w_en_in, req1_r_en_in, req1_w_en_in;
  logic [31:0] req0_address_in, req0_write_data_in, req1_address_in, req1_write_data_in;
  logic [63:0] req0_read_data_out, req1_read_data_out, mem_read_data_in;
  logic        req0_ready_out, req1_ready_out;
  logic        mem_r_en_out, mem_w_en_out, mem_ready_in;
  logic [31:0] mem_address_out, mem_write_data_out;
  logic [1:0]  grant_out;
  logic        busy_out;

  int checks = 0;
  int errors = 0;
  int exp_last = 1;  // model: port served most recently (reset favours port 0)

  sram_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .req0_r_en_in       (req0_r_en_in),
    .req0_w_en_in       (req0_w_en_in),
    .req0_address_in    (req0_address_in),
    .req0_write_data_in (req0_write_data_in),
    .req0_read_data_out (req0_read_data_out),
    .req0_ready_out     (req0_ready_out),
    .req1_r_en_in       (req1_r_en_in),
    .req1_w_en_in       (req1_w_en_in),
    .req1_address_in    (req1_address_in),
    .req1_write_data_in (req1_write_data_in),
    .req1_read_data_out (req1_read_data_out),
    .req1_ready_out     (req1_ready_out),
    .mem_r_en_out       (mem_r_en_out),
    .mem_w_en_out       (mem_w_en_out),
    .mem_address_out    (mem_address_out),
    .mem_write_data_out (mem_write_data_out),
    .mem_read_data_in   (mem_read_data_in),
    .mem_ready_in       (mem_ready_in),
    .grant_out          (grant_out),
    .busy_out           (busy_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req0_r_en_in = 0; req0_w_en_in = 0; req1_r_en_in = 0; req1_w_en_in = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_reqs(); mem_ready_in = 0;
    tick();
    rst = 0;
    exp_last = 1;
  endtask

  task automatic test_reset();
    req0_address_in = 0; req1_address_in = 0; req0_write_data_in = 0; req1_write_data_in = 0;
    mem_read_data_in = 0;
    do_reset();
    checks++;
    if ({mem_r_en_out, mem_w_en_out, grant_out, busy_out, req0_ready_out, req1_ready_out}
        !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got r%b w%b g%b b%b rd%b%b, required all 0", mem_r_en_out,
               mem_w_en_out, grant_out, busy_out, req0_ready_out, req1_ready_out);
    end
    checks++;
    if ({mem_address_out, mem_write_data_out} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: addr %h data %h, required 0", mem_address_out, mem_write_data_out);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req0_r_en_in = 1; req0_address_in = 32'h10;
    tick();
    checks++;
    if ({mem_r_en_out, mem_w_en_out, grant_out, busy_out} !== 5'b10011 ||
        mem_address_out !== 32'h10) begin
      errors++;
      $display("FAIL single_grant: r%b w%b g%b b%b a%h, required r1 w0 g01 b1 a10",
               mem_r_en_out, mem_w_en_out, grant_out, busy_out, mem_address_out);
    end
    tick(); tick();
    mem_read_data_in = 64'h1122334455667788; mem_ready_in = 1;
    #1;
    checks++;
    if (req0_ready_out !== 1 || req1_ready_out !== 0 ||
        req0_read_data_out !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL single_ready: rdy0 %b rdy1 %b data %h, required 1 0 1122334455667788",
               req0_ready_out, req1_ready_out, req0_read_data_out);
    end
    tick();
    mem_ready_in = 0; clear_reqs(); exp_last = 0;
    checks++;
    if ({mem_r_en_out, grant_out, busy_out, req0_ready_out} !== 5'b0) begin
      errors++;
      $display("FAIL single_idle: r%b g%b b%b rdy0 %b, required all 0", mem_r_en_out, grant_out,
               busy_out, req0_ready_out);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0_r_en_in = 1; req0_address_in = 32'h20;
    req1_w_en_in = 1; req1_address_in = 32'h30; req1_write_data_in = 32'hDEADBEEF;
    tick();
    checks++;
    if (grant_out !== 2'b01 || mem_r_en_out !== 1 || mem_address_out !== 32'h20) begin
      errors++;
      $display("FAIL sim_first: g%b r%b a%h, required g01 r1 a20", grant_out, mem_r_en_out,
               mem_address_out);
    end
    mem_ready_in = 1;
    #1;
    checks++;
    if (req0_ready_out !== 1 || req1_ready_out !== 0) begin
      errors++;
      $display("FAIL sim_ready0: rdy0 %b rdy1 %b, required 1 0", req0_ready_out, req1_ready_out);
    end
    tick();
    mem_ready_in = 0; req0_r_en_in = 0;
    checks++;
    if (busy_out !== 0 || mem_w_en_out !== 0 || grant_out !== 2'b00) begin
      errors++;
      $display("FAIL sim_gap: b%b w%b g%b, required idle", busy_out, mem_w_en_out, grant_out);
    end
    tick();
    checks++;
    if (grant_out !== 2'b10 || mem_w_en_out !== 1 || mem_r_en_out !== 0 ||
        mem_address_out !== 32'h30 || mem_write_data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sim_second: g%b w%b r%b a%h d%h, required g10 w1 r0 a30 dDEADBEEF",
               grant_out, mem_w_en_out, mem_r_en_out, mem_address_out, mem_write_data_out);
    end
    mem_ready_in = 1;
    #1;
    checks++;
    if (req1_ready_out !== 1 || req0_ready_out !== 0) begin
      errors++;
      $display("FAIL sim_ready1: rdy0 %b rdy1 %b, required 0 1", req0_ready_out, req1_ready_out);
    end
    tick();
    mem_ready_in = 0; clear_reqs(); exp_last = 1;
  endtask

  task automatic test_contention();
    int win;
    do_reset();
    req0_r_en_in = 1; req0_address_in = 32'h100;
    req1_r_en_in = 1; req1_address_in = 32'h200;
    for (int n = 0; n < 4; n++) begin
      win = (exp_last == 0) ? 1 : 0;
      checks++;
      if (win !== n % 2) begin
        errors++;
        $display("FAIL cont_model: txn %0d model winner %0d, required %0d", n, win, n % 2);
      end
      tick();
      checks++;
      if (grant_out !== (win ? 2'b10 : 2'b01) ||
          mem_address_out !== (win ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL cont_grant: txn %0d g%b a%h, required port %0d", n, grant_out,
                 mem_address_out, win);
      end
      repeat ($urandom_range(0, 2)) tick();
      mem_ready_in = 1;
      #1;
      checks++;
      if (req0_ready_out !== (win == 0) || req1_ready_out !== (win == 1)) begin
        errors++;
        $display("FAIL cont_ready: txn %0d rdy0 %b rdy1 %b, required port %0d", n,
                 req0_ready_out, req1_ready_out, win);
      end
      tick();
      mem_ready_in = 0; exp_last = win;
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_mid_change();
    do_reset();
    req0_r_en_in = 1; req0_address_in = 32'h40;
    tick();
    req0_address_in = 32'h44; req0_r_en_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_address_out !== 32'h40 || mem_r_en_out !== 1 || grant_out !== 2'b01) begin
        errors++;
        $display("FAIL mid_hold: cyc %0d a%h r%b g%b, required a40 r1 g01", i, mem_address_out,
                 mem_r_en_out, grant_out);
      end
    end
    mem_ready_in = 1;
    #1;
    checks++;
    if (req0_ready_out !== 1) begin
      errors++;
      $display("FAIL mid_ready: rdy0 %b, required 1", req0_ready_out);
    end
    tick();
    mem_ready_in = 0; exp_last = 0;
  endtask

  task automatic test_precedence_stray();
    req1_r_en_in = 1; req1_w_en_in = 1; req1_address_in = 32'h50; req1_write_data_in = 32'h5A5A;
    tick();
    checks++;
    if (mem_w_en_out !== 1 || mem_r_en_out !== 0 || grant_out !== 2'b10) begin
      errors++;
      $display("FAIL prec_write: w%b r%b g%b, required w1 r0 g10", mem_w_en_out, mem_r_en_out,
               grant_out);
    end
    mem_ready_in = 1;
    tick();
    mem_ready_in = 0; clear_reqs(); exp_last = 1;
    tick();
    mem_ready_in = 1;
    #1;
    checks++;
    if (req0_ready_out !== 0 || req1_ready_out !== 0) begin
      errors++;
      $display("FAIL stray_ready: rdy0 %b rdy1 %b, required 0 0", req0_ready_out, req1_ready_out);
    end
    tick();
    mem_ready_in = 0;
    checks++;
    if (busy_out !== 0 || grant_out !== 2'b00 || mem_w_en_out !== 0 || mem_r_en_out !== 0) begin
      errors++;
      $display("FAIL stray_state: b%b g%b w%b r%b, required idle", busy_out, grant_out,
               mem_w_en_out, mem_r_en_out);
    end
  endtask

  task automatic test_reset_busy();
    req1_r_en_in = 1; req1_address_in = 32'h60;
    tick();
    rst = 1; clear_reqs();
    tick();
    rst = 0; exp_last = 1;
    mem_ready_in = 1;
    #1;
    checks++;
    if ({mem_r_en_out, mem_w_en_out, grant_out, busy_out, req0_ready_out, req1_ready_out}
        !== 7'b0) begin
      errors++;
      $display("FAIL rst_busy: r%b w%b g%b b%b rdy %b%b, required all 0", mem_r_en_out,
               mem_w_en_out, grant_out, busy_out, req0_ready_out, req1_ready_out);
    end
    tick();
    mem_ready_in = 0;
    req0_r_en_in = 1; req1_r_en_in = 1;
    tick();
    checks++;
    if (grant_out !== 2'b01) begin
      errors++;
      $display("FAIL rst_tie: g%b, required 01", grant_out);
    end
    mem_ready_in = 1;
    tick();
    mem_ready_in = 0; clear_reqs(); exp_last = 0;
  endtask

  task automatic test_random();
    logic r0, w0, r1, w1, want0, want1, e_w;
    logic [31:0] e_a, e_d;
    logic [63:0] rd;
    int win;
    for (int t = 0; t < 80; t++) begin
      r0 = ($urandom_range(0, 2) == 0); w0 = ($urandom_range(0, 2) == 0);
      r1 = ($urandom_range(0, 2) == 0); w1 = ($urandom_range(0, 2) == 0);
      req0_r_en_in = r0; req0_w_en_in = w0; req1_r_en_in = r1; req1_w_en_in = w1;
      req0_address_in = $urandom & 32'hFFFF_FFFC; req1_address_in = $urandom & 32'hFFFF_FFFC;
      req0_write_data_in = $urandom; req1_write_data_in = $urandom;
      want0 = r0 | w0; want1 = r1 | w1;
      if (!want0 && !want1) begin
        mem_ready_in = $urandom_range(0, 1);
        #1;
        checks++;
        if (req0_ready_out !== 0 || req1_ready_out !== 0 || busy_out !== 0) begin
          errors++;
          $display("FAIL rnd_idle: t%0d rdy %b%b b%b, required 0", t, req0_ready_out,
                   req1_ready_out, busy_out);
        end
        tick();
        mem_ready_in = 0;
        continue;
      end
      if (want0 && want1) win = (exp_last == 0) ? 1 : 0;
      else win = want1 ? 1 : 0;
      e_w = win ? w1 : w0;
      e_a = win ? req1_address_in : req0_address_in;
      e_d = win ? req1_write_data_in : req0_write_data_in;
      tick();
      checks++;
      if (grant_out !== (win ? 2'b10 : 2'b01) || mem_w_en_out !== e_w || mem_r_en_out !== !e_w ||
          mem_address_out !== e_a || mem_write_data_out !== e_d || busy_out !== 1) begin
        errors++;
        $display("FAIL rnd_grant: t%0d g%b w%b r%b a%h d%h, required port %0d w%b a%h d%h", t,
                 grant_out, mem_w_en_out, mem_r_en_out, mem_address_out, mem_write_data_out,
                 win, e_w, e_a, e_d);
      end
      repeat ($urandom_range(0, 3)) begin
        req0_r_en_in = $urandom_range(0, 1); req1_w_en_in = $urandom_range(0, 1);
        req0_address_in = $urandom; req1_address_in = $urandom;
        tick();
        checks++;
        if (mem_address_out !== e_a || mem_w_en_out !== e_w || mem_write_data_out !== e_d) begin
          errors++;
          $display("FAIL rnd_hold: t%0d a%h w%b d%h, required a%h w%b d%h", t, mem_address_out,
                   mem_w_en_out, mem_write_data_out, e_a, e_w, e_d);
        end
      end
      rd = {$urandom, $urandom};
      mem_read_data_in = rd; mem_ready_in = 1;
      #1;
      checks++;
      if (req0_ready_out !== (win == 0) || req1_ready_out !== (win == 1) ||
          (win ? req1_read_data_out : req0_read_data_out) !== rd) begin
        errors++;
        $display("FAIL rnd_ready: t%0d rdy %b%b data0 %h data1 %h, required port %0d data %h", t,
                 req0_ready_out, req1_ready_out, req0_read_data_out, req1_read_data_out, win, rd);
      end
      tick();
      mem_ready_in = 0; exp_last = win;
    end
    clear_reqs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_contention();
    test_mid_change();
    test_precedence_stray();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
